// File: rtl/dmem_pipe_if.sv
// rtl/dmem_pipe_if.sv - request/response bus between a load/store client and dmem_pipe
interface dmem_pipe_if #(
   parameter int DW = 16,
   parameter int AW = 12
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_be;
   logic            rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - single-port data memory, byte enables, RD_LAT read pipe; DMEM_PIPE_CLEAR_EN adds a zeroing sweep
module dmem_pipe #(
   parameter int DW     = 16,
   parameter int AW     = 12,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   dmem_pipe_if.slave bus,
   output logic       busy
);
   localparam int NB = DW / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   mem [DEPTH];

   logic            accept;
   logic            in_range;
   logic            rd_acc;
   logic [IW-1:0]   rd_idx;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [DW-1:0]   wr_data;
   logic [NB-1:0]   wr_be;

   logic [RD_LAT-1:0] pv_q, pv_d;
   logic [RD_LAT-1:0] pe_q, pe_d;
   logic [DW-1:0]     pd_q [RD_LAT];
   logic [DW-1:0]     pd_d [RD_LAT];

`ifdef DMEM_PIPE_CLEAR_EN
   logic [IW-1:0]   clr_q, clr_d;
`endif

   // Request decode: acceptance, range check and array index
   always_comb begin
      bus.req_ready = (state_q == RUN) && !rst;
      accept        = bus.req_valid && bus.req_ready;
      in_range      = ({1'b0, bus.req_addr} < (AW+1)'(DEPTH));
      rd_acc        = accept && !bus.req_we;
      rd_idx        = bus.req_addr[IW-1:0];
   end

   // FSM next state; in INIT the optional sweep counter walks the array
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
`ifdef DMEM_PIPE_CLEAR_EN
      clr_d   = clr_q;
      busy    = (state_q == INIT);
`endif
      case (state_q)
         INIT: begin
`ifdef DMEM_PIPE_CLEAR_EN
            clr_d = clr_q + IW'(1);
            if (clr_q == IW'(DEPTH - 1)) begin
               state_d = RUN;
            end
`else
            state_d = RUN;
`endif
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
      if (rst) begin
         state_d = INIT;
`ifdef DMEM_PIPE_CLEAR_EN
         clr_d   = '0;
`endif
      end
   end

   // Write port: sweep zeroing during INIT, otherwise accepted in-range writes
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = rd_idx;
      wr_data = bus.req_wdata;
      wr_be   = bus.req_be;
`ifdef DMEM_PIPE_CLEAR_EN
      if (!rst && state_q == INIT) begin
         wr_en   = 1'b1;
         wr_idx  = clr_q;
         wr_data = '0;
         wr_be   = '1;
      end
`endif
      if (accept && bus.req_we && in_range) begin
         wr_en = 1'b1;
      end
   end

   // Read pipeline: stage 0 captures the array word, later stages shift it out
   always_comb begin
      pv_d = '0;
      pe_d = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         pd_d[i] = '0;
      end
      if (!rst) begin
         pv_d[0] = rd_acc;
         pe_d[0] = rd_acc && !in_range;
         pd_d[0] = (rd_acc && in_range) ? mem[rd_idx] : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
         end
      end
   end

   // Response outputs come straight from the last pipe stage
   always_comb begin
      bus.rsp_valid = pv_q[RD_LAT-1];
      bus.rsp_err   = pe_q[RD_LAT-1];
      bus.rsp_rdata = pd_q[RD_LAT-1];
   end

   // State and pipeline registers
   always_ff @(posedge clk) begin
      state_q <= state_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      for (int i = 0; i < RD_LAT; i++) begin
         pd_q[i] <= pd_d[i];
      end
`ifdef DMEM_PIPE_CLEAR_EN
      clr_q   <= clr_d;
`endif
   end

   // Storage array with per-byte write enables
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end
endmodule
